// File: rtl/stall_pkg.sv
// Shared encodings and defaults for the pipeline stall controller and its
// multiply/divide busy tracker.
package stall_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;

    localparam logic [1:0] USE_D    = 2'b00;
    localparam logic [1:0] USE_E    = 2'b01;
    localparam logic [1:0] USE_NONE = 2'b11;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic {MdIdle, MdRun} md_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Multiply/divide occupancy tracker: loads the op latency on a valid start and
// counts down; busy covers the start cycle plus every nonzero-count cycle.
module md_busy_tracker
    import stall_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [2:0] md_op_i,
    output logic       busy_o
);

    localparam int unsigned CntW = $clog2(max_u(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            is_mult, is_div, start_ok;

    always_comb begin
        is_mult  = (md_op_i == MD_MULT) || (md_op_i == MD_MULTU);
        is_div   = (md_op_i == MD_DIV) || (md_op_i == MD_DIVU);
        start_ok = start_i && (is_mult || is_div);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start arriving while running is dropped; the D-stage stall prevents it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MdIdle: begin
                if (start_ok) begin
                    cnt_d   = is_mult ? MultLoad : DivLoad;
                    state_d = MdRun;
                end
            end
            MdRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = MdIdle;
                end
            end
            default: begin
                state_d = MdIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_o = start_ok || (cnt_q != '0);
    end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard/stall controller: operand hazards against E and M plus
// multiply/divide occupancy. Optional perf counters under STALL_PERF_EN.
module stall_ctrl
    import stall_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [1:0]  TuseRsD,
    input  logic [1:0]  TuseRtD,
    input  logic        MDInstrD,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic [4:0]  WriteRegE,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic [4:0]  WriteRegM,
    input  logic        StartE,
    input  logic [2:0]  MDOpE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        BusyMD,
    output logic [31:0] HazStallCnt,
    output logic [31:0] MDStallCnt
);

    logic       busy;
    logic [1:0] tnew_e, tnew_m;
    logic       match_rs_e, match_rt_e, match_rs_m, match_rt_m;
    logic       haz_rs, haz_rt, haz_stall, md_stall, stall;

    md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_tracker (
        .clk_i   (Clk),
        .reset_i (Reset),
        .start_i (StartE),
        .md_op_i (MDOpE),
        .busy_o  (busy)
    );

    // $0 is hardwired, so a zero destination never creates a dependency.
    always_comb begin
        tnew_e     = MemtoRegE ? 2'd2 : 2'd1;
        tnew_m     = MemtoRegM ? 2'd1 : 2'd0;
        match_rs_e = RegWriteE && (WriteRegE != 5'd0) && (WriteRegE == RsD);
        match_rt_e = RegWriteE && (WriteRegE != 5'd0) && (WriteRegE == RtD);
        match_rs_m = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsD);
        match_rt_m = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtD);
        haz_rs     = (TuseRsD != USE_NONE)
                     && ((match_rs_e && (TuseRsD < tnew_e)) || (match_rs_m && (TuseRsD < tnew_m)));
        haz_rt     = (TuseRtD != USE_NONE)
                     && ((match_rt_e && (TuseRtD < tnew_e)) || (match_rt_m && (TuseRtD < tnew_m)));
        haz_stall  = haz_rs || haz_rt;
        md_stall   = MDInstrD && busy;
        stall      = haz_stall || md_stall;
    end

    always_comb begin
        StallF = stall;
        StallD = stall;
        FlushE = stall;
        BusyMD = busy;
    end

`ifdef STALL_PERF_EN
    logic [31:0] haz_cnt_q, haz_cnt_d;
    logic [31:0] md_cnt_q, md_cnt_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            haz_cnt_q <= '0;
            md_cnt_q  <= '0;
        end else begin
            haz_cnt_q <= haz_cnt_d;
            md_cnt_q  <= md_cnt_d;
        end
    end

    // MD waits are only attributed when no operand hazard explains the stall.
    always_comb begin
        haz_cnt_d = haz_cnt_q;
        md_cnt_d  = md_cnt_q;
        if (haz_stall) begin
            haz_cnt_d = haz_cnt_q + 32'd1;
        end else if (md_stall) begin
            md_cnt_d = md_cnt_q + 32'd1;
        end
    end

    always_comb begin
        HazStallCnt = haz_cnt_q;
        MDStallCnt  = md_cnt_q;
    end
`else
    always_comb begin
        HazStallCnt = 32'd0;
        MDStallCnt  = 32'd0;
    end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: directed vectors push expectations, a
// negedge monitor pops and compares them.
module tb_stall_ctrl;
    import stall_pkg::*;

    localparam int unsigned MultC = 5;
    localparam int unsigned DivC  = 10;
`ifdef STALL_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  RsD, RtD, WriteRegE, WriteRegM;
    logic [1:0]  TuseRsD, TuseRtD;
    logic        MDInstrD, RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, StartE;
    logic [2:0]  MDOpE;
    logic        StallF, StallD, FlushE, BusyMD;
    logic [31:0] HazStallCnt, MDStallCnt;

    typedef struct {
        string       name;
        logic        stall;
        logic        busy;
        bit          chk_cnt;
        logic [31:0] haz;
        logic [31:0] md;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    stall_ctrl #(
        .MULT_CYCLES (MultC),
        .DIV_CYCLES  (DivC)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .RsD         (RsD),
        .RtD         (RtD),
        .TuseRsD     (TuseRsD),
        .TuseRtD     (TuseRtD),
        .MDInstrD    (MDInstrD),
        .RegWriteE   (RegWriteE),
        .MemtoRegE   (MemtoRegE),
        .WriteRegE   (WriteRegE),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .WriteRegM   (WriteRegM),
        .StartE      (StartE),
        .MDOpE       (MDOpE),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushE      (FlushE),
        .BusyMD      (BusyMD),
        .HazStallCnt (HazStallCnt),
        .MDStallCnt  (MDStallCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got %0h expected %0h", name, what, act, exp);
        end
    endtask

    function automatic logic [31:0] pc(input int v);
        return PerfEn ? 32'(v) : 32'd0;
    endfunction

    task automatic expect_out(input string name, input logic s, input logic b);
        exp_t e;
        e.name = name; e.stall = s; e.busy = b; e.chk_cnt = 1'b0; e.haz = '0; e.md = '0;
        sb_q.push_back(e);
    endtask

    task automatic expect_cnt(input string name, input logic s, input logic b,
                              input int h, input int m);
        exp_t e;
        e.name = name; e.stall = s; e.busy = b; e.chk_cnt = 1'b1; e.haz = pc(h); e.md = pc(m);
        sb_q.push_back(e);
    endtask

    task automatic idle();
        Reset = 1'b0; RsD = 5'd0; RtD = 5'd0; TuseRsD = USE_NONE; TuseRtD = USE_NONE;
        MDInstrD = 1'b0; RegWriteE = 1'b0; MemtoRegE = 1'b0; WriteRegE = 5'd0;
        RegWriteM = 1'b0; MemtoRegM = 1'b0; WriteRegM = 5'd0; StartE = 1'b0; MDOpE = 3'b111;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check(e.name, "StallF", 32'(StallF), 32'(e.stall));
                check(e.name, "StallD", 32'(StallD), 32'(e.stall));
                check(e.name, "FlushE", 32'(FlushE), 32'(e.stall));
                check(e.name, "BusyMD", 32'(BusyMD), 32'(e.busy));
                if (e.chk_cnt) begin
                    check(e.name, "HazStallCnt", HazStallCnt, e.haz);
                    check(e.name, "MDStallCnt", MDStallCnt, e.md);
                end
            end
        end
    end

    initial begin : stimulus
        idle(); Reset = 1'b1;
        tick(); idle(); Reset = 1'b1; expect_out("reset_idle", 1'b0, 1'b0);
        tick(); idle(); Reset = 1'b1;
        RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd1; RsD = 5'd1; TuseRsD = USE_E;
        expect_out("reset_comb_haz", 1'b1, 1'b0);

        // load-use, Tuse E
        tick(); idle();
        RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd1; RsD = 5'd1; TuseRsD = USE_E;
        expect_cnt("lu_e", 1'b1, 1'b0, 0, 0);
        tick(); idle();
        RegWriteM = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd1; RsD = 5'd1; TuseRsD = USE_E;
        expect_cnt("lu_m", 1'b0, 1'b0, 1, 0);

        // branch after load
        tick(); idle();
        RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd2; RtD = 5'd2; TuseRtD = USE_D;
        expect_cnt("br_e", 1'b1, 1'b0, 1, 0);
        tick(); idle();
        RegWriteM = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd2; RtD = 5'd2; TuseRtD = USE_D;
        expect_cnt("br_m", 1'b1, 1'b0, 2, 0);
        tick(); idle(); RtD = 5'd2; TuseRtD = USE_D;
        expect_cnt("br_go", 1'b0, 1'b0, 3, 0);

        tick(); idle();
        RegWriteE = 1'b1; WriteRegE = 5'd0; RegWriteM = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd0;
        TuseRsD = USE_D; TuseRtD = USE_D;
        expect_out("zero_reg", 1'b0, 1'b0);
        tick(); idle(); RegWriteE = 1'b1; WriteRegE = 5'd7; RsD = 5'd7; TuseRsD = USE_D;
        expect_out("alu_e_br", 1'b1, 1'b0);
        tick(); idle(); RegWriteE = 1'b1; WriteRegE = 5'd7; RsD = 5'd7; TuseRsD = USE_E;
        expect_out("alu_e_add", 1'b0, 1'b0);
        tick(); idle(); RegWriteM = 1'b1; WriteRegM = 5'd7; RtD = 5'd7; TuseRtD = USE_D;
        expect_out("alu_m_br", 1'b0, 1'b0);
        tick(); idle(); RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd5; RsD = 5'd5; RtD = 5'd5;
        expect_out("use_none", 1'b0, 1'b0);
        tick(); idle(); MemtoRegE = 1'b1; WriteRegE = 5'd4; RsD = 5'd4; TuseRsD = USE_E;
        expect_cnt("no_regwrite", 1'b0, 1'b0, 4, 0);

        // mult with mflo waiting in D
        tick(); idle(); Reset = 1'b1; expect_out("rst2", 1'b0, 1'b0);
        for (int i = 0; i <= 5; i++) begin
            tick(); idle(); MDInstrD = 1'b1;
            if (i == 0) begin StartE = 1'b1; MDOpE = MD_MULT; end
            expect_cnt($sformatf("mult_c%0d", i), 1'b1, 1'b1, 0, i);
        end
        tick(); idle(); MDInstrD = 1'b1; expect_cnt("mult_rel", 1'b0, 1'b0, 0, 6);

        for (int i = 0; i <= 10; i++) begin
            tick(); idle(); MDInstrD = 1'b1;
            if (i == 0) begin StartE = 1'b1; MDOpE = MD_DIV; end
            expect_cnt($sformatf("div_c%0d", i), 1'b1, 1'b1, 0, 6 + i);
        end
        tick(); idle(); MDInstrD = 1'b1; expect_cnt("div_rel", 1'b0, 1'b0, 0, 17);

        tick(); idle(); MDInstrD = 1'b1; StartE = 1'b1; MDOpE = 3'b100;
        expect_out("bad_op", 1'b0, 1'b0);
        tick(); idle(); MDInstrD = 1'b1; expect_out("bad_op_after", 1'b0, 1'b0);

        // multu with a non-MD instruction in D: busy but no stall
        for (int i = 0; i <= 5; i++) begin
            tick(); idle();
            if (i == 0) begin StartE = 1'b1; MDOpE = MD_MULTU; end
            expect_out($sformatf("multu_c%0d", i), 1'b0, 1'b1);
        end
        tick(); idle(); expect_out("multu_done", 1'b0, 1'b0);

        // reset in cycle 3 of a running divu
        for (int i = 0; i <= 3; i++) begin
            tick(); idle(); MDInstrD = 1'b1;
            if (i == 0) begin StartE = 1'b1; MDOpE = MD_DIVU; end
            if (i == 3) Reset = 1'b1;
            expect_out($sformatf("divu_c%0d", i), 1'b1, 1'b1);
        end
        tick(); idle(); MDInstrD = 1'b1; expect_cnt("rst_mid_rel", 1'b0, 1'b0, 0, 0);
        tick(); idle(); MDInstrD = 1'b1; expect_out("rst_mid_stay", 1'b0, 1'b0);

        // one load-use stall, then a mult with mfhi already in D
        tick(); idle();
        RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd3; RsD = 5'd3; TuseRsD = USE_E;
        expect_cnt("perf_lu", 1'b1, 1'b0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            tick(); idle(); MDInstrD = 1'b1;
            if (i == 1) begin StartE = 1'b1; MDOpE = MD_MULT; end
            expect_cnt($sformatf("perf_md%0d", i), 1'b1, 1'b1, 1, i - 1);
        end
        tick(); idle(); MDInstrD = 1'b1; expect_cnt("perf_end", 1'b0, 1'b0, 1, 6);

        repeat (3) tick();
        check("drain", "pending", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
